// File: rtl/core_ctrl_pkg.sv
// Shared control definitions for the multi-cycle core: state encoding, ALU op and operand-select codes, opcodes.
// Latency: none (types, constants and a pure decode function).
// Backpressure: not applicable.
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RST      = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_WB_MEM   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_WB_R     = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_HALT     = 4'd15
    } state_t;

    // aluop codes consumed by the ALU-control decoder
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // second ALU operand select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BIMM = 2'b11;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_BEQ    = 3'b000;

    // Successor of DECODE; anything unsupported lands in HALT.
    function automatic state_t decode_next(input logic [6:0] opcode, input logic [2:0] f3);
        state_t nxt;
        nxt = ST_HALT;
        if (opcode == OP_R)
            nxt = ST_EXEC_R;
        else if (opcode == OP_LOAD || opcode == OP_STORE)
            nxt = ST_MEM_ADDR;
        else if (opcode == OP_BRANCH && f3 == F3_BEQ)
            nxt = ST_BRANCH;
        return nxt;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of one memory access and flags when the wait limit is reached.
// Latency: count updates one cycle after each wait; expired is combinational from count and mem_ready.
// Backpressure: none; a ready cycle or leaving the memory state restarts the count from zero.
module mem_wait_timer
    import core_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic mem_ready,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // Zero outside memory states and on completion, so each access starts at 0; saturate at the limit.
    always_ff @(posedge clk) begin
        if (rst || !active || mem_ready)
            count <= '0;
        else if (count != LIMIT)
            count <= count + CW'(1);
    end

    // A ready cycle at the limit still completes the access, so mem_ready masks the expiry.
    assign expired = (TIMEOUT != 0) && active && !mem_ready && (count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle core: fetch, decode, execute, memory, writeback over a shared datapath.
// Latency: R-type 4, load 5, store 4, branch 3 cycles with zero wait states; outputs decoded from the state register.
// Backpressure: stalls in FETCH/MEM_RD/MEM_WR until mem_ready; a bounded wait halts with fault_timeout.
module multicycle_control
    import core_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] f3,
    input  logic       mem_ready,
    output logic [1:0] aluop,
    output logic       alusrc_a,
    output logic [1:0] alusrc_b,
    output logic       pc_source,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       retire,
    output logic       fault_illegal,
    output logic       fault_timeout,
    output logic [3:0] state
);

    state_t st;
    logic   wait_st;
    logic   expired;

    assign wait_st = (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .active   (wait_st),
        .mem_ready(mem_ready),
        .expired  (expired)
    );

    // State sequencing and sticky fault flags; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= ST_RST;
            fault_illegal <= 1'b0;
            fault_timeout <= 1'b0;
        end else begin
            case (st)
                ST_RST:      st <= ST_FETCH;
                ST_FETCH: begin
                    if (mem_ready) begin
                        st <= ST_DECODE;
                    end else if (expired) begin
                        st            <= ST_HALT;
                        fault_timeout <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    st <= decode_next(opcode, f3);
                    if (decode_next(opcode, f3) == ST_HALT)
                        fault_illegal <= 1'b1;
                end
                ST_MEM_ADDR: st <= (opcode == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
                ST_MEM_RD: begin
                    if (mem_ready) begin
                        st <= ST_WB_MEM;
                    end else if (expired) begin
                        st            <= ST_HALT;
                        fault_timeout <= 1'b1;
                    end
                end
                ST_WB_MEM:   st <= ST_FETCH;
                ST_MEM_WR: begin
                    if (mem_ready) begin
                        st <= ST_FETCH;
                    end else if (expired) begin
                        st            <= ST_HALT;
                        fault_timeout <= 1'b1;
                    end
                end
                ST_EXEC_R:   st <= ST_WB_R;
                ST_WB_R:     st <= ST_FETCH;
                ST_BRANCH:   st <= ST_FETCH;
                ST_HALT:     st <= ST_HALT;
                default:     st <= ST_RST;
            endcase
        end
    end

    // Moore decode of the state register; only fetch strobes and the store retire look at mem_ready.
    always_comb begin
        aluop         = ALU_ADD;
        alusrc_a      = 1'b0;
        alusrc_b      = SRCB_RS2;
        pc_source     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        retire        = 1'b0;
        case (st)
            ST_FETCH: begin
                mem_read = 1'b1;
                alusrc_b = SRCB_FOUR;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            ST_DECODE: begin
                alusrc_b = SRCB_BIMM;
            end
            ST_MEM_ADDR: begin
                alusrc_a = 1'b1;
                alusrc_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            ST_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                retire    = mem_ready;
            end
            ST_EXEC_R: begin
                alusrc_a = 1'b1;
                aluop    = ALU_FUNCT;
            end
            ST_WB_R: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            ST_BRANCH: begin
                alusrc_a      = 1'b1;
                aluop         = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                retire        = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = st;

endmodule
